// File: rtl/tcp_rx_seq_engine_pkg.sv
// ---------------------------------------------------------------------------
// Shared types for the slow-path TCP receive sequence engine.
//
// packet_struct_pkg : parsed TCP header and payload-buffer descriptor.
// tcp_misc_pkg      : flow ID width and the receive-engine FSM state enum.
// tcp_pkg           : per-flow receive state, scheduler command and the
//                     ACK-pending command builder, which the timeout engine
//                     shares.
// ---------------------------------------------------------------------------

package packet_struct_pkg;

  localparam int TCP_SEQ_W      = 32;
  localparam int PAYLOAD_LEN_W  = 16;
  localparam int PAYLOAD_ADDR_W = 32;

  // Bit position of FIN inside tcp_pkt_hdr.flags
  localparam int TCP_FLAG_FIN = 0;

  typedef struct packed {
    logic [15:0]          src_port;
    logic [15:0]          dst_port;
    logic [TCP_SEQ_W-1:0] seq_num;
    logic [TCP_SEQ_W-1:0] ack_num;
    logic [3:0]           raw_data_offset;
    logic [3:0]           reserved;
    logic [7:0]           flags;
    logic [15:0]          win_size;
  } tcp_pkt_hdr;

  typedef struct packed {
    logic [PAYLOAD_ADDR_W-1:0] payload_addr;
    logic [PAYLOAD_LEN_W-1:0]  payload_len;
  } payload_buf_struct;

endpackage

package tcp_misc_pkg;

  localparam int FLOWID_W = 8;

  // Receive sequence engine FSM
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_RESP = 3'd2,
    CALC    = 3'd3,
    OUT     = 3'd4
  } rx_seq_state_e;

endpackage

package tcp_pkg;

  import packet_struct_pkg::*;
  import tcp_misc_pkg::*;

  typedef struct packed {
    logic [TCP_SEQ_W-1:0] ack_num;
  } ack_state_struct;

  // Per-flow receive state as held in the state RAM
  typedef struct packed {
    ack_state_struct our_ack_state;
    logic [15:0]     our_win;
  } smol_rx_state_struct;

  typedef struct packed {
    logic [FLOWID_W-1:0] flowid;
    logic                set_ack_pending;
    logic                set_data_pending;
    logic                set_rt_pending;
  } sched_cmd_struct;

  // Command telling the transmit scheduler that an ACK is owed on a flow
  function automatic sched_cmd_struct build_ack_pending_cmd(
    input logic [FLOWID_W-1:0] flowid
  );
    sched_cmd_struct cmd;
    cmd                 = '0;
    cmd.flowid          = flowid;
    cmd.set_ack_pending = 1'b1;
    return cmd;
  endfunction

endpackage

// File: rtl/tcp_rx_seq_engine_calc.sv
// ---------------------------------------------------------------------------
// tcp_rx_seq_calc: combinational sequence check for one received packet.
//
// Ports:
//   exp_ack      in   expected sequence number (our current ack_num)
//   seq_num      in   sequence number carried by the packet
//   payload_len  in   payload byte count
//   fin          in   FIN flag of the packet
//   in_order     out  packet starts exactly at exp_ack
//   accept       out  in order and consumes sequence space
//   has_adv      out  packet consumes sequence space (payload or FIN)
//   commit       out  accepted and carries payload bytes
//   new_ack      out  exp_ack advanced by the consumed space, mod 2^32
// ---------------------------------------------------------------------------
module tcp_rx_seq_calc
  import packet_struct_pkg::*;
(
  input  logic [TCP_SEQ_W-1:0]     exp_ack,
  input  logic [TCP_SEQ_W-1:0]     seq_num,
  input  logic [PAYLOAD_LEN_W-1:0] payload_len,
  input  logic                     fin,
  output logic                     in_order,
  output logic                     accept,
  output logic                     has_adv,
  output logic                     commit,
  output logic [TCP_SEQ_W-1:0]     new_ack
);

  // FIN occupies one unit of sequence space, so the advance needs one
  // extra bit over the payload length.
  logic [PAYLOAD_LEN_W:0] adv;

  assign adv      = {1'b0, payload_len} + {{PAYLOAD_LEN_W{1'b0}}, fin};
  assign in_order = (seq_num == exp_ack);
  assign has_adv  = (adv != '0);
  assign accept   = in_order && has_adv;
  assign commit   = accept && (payload_len != '0);

  // Plain modular add: advancing past 0xFFFFFFFF wraps naturally
  assign new_ack  = exp_ack + {{(TCP_SEQ_W-PAYLOAD_LEN_W-1){1'b0}}, adv};

endmodule

// File: rtl/tcp_rx_seq_engine.sv
// ---------------------------------------------------------------------------
// tcp_rx_seq_engine: receive-side sequence/ACK engine.
//
// Takes one parsed TCP header at a time, reads the flow's receive state,
// checks the sequence number against the expected ACK number, then writes
// back the advanced ack_num, commits in-order payload to the receive buffer
// and posts an ACK-pending command to the transmit scheduler.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   rx_pkt_hdr_val/_rdy              packet in (flowid, header, payload)
//   rx_pipe_rx_state_rd_req_*        state RAM read request
//   rx_state_rx_pipe_rd_resp_*       state RAM read response
//   rx_pipe_rx_state_wr_req_*        state RAM write (advanced ack_num)
//   rx_sched_update_*                ACK-pending command to the scheduler
//   rx_buf_commit_*                  keep in-order payload in the buffer
//
// Build option:
//   TCP_RX_SEQ_STATS_EN  adds rx_stat_accept_cnt / rx_stat_ooo_cnt, 32-bit
//                        wrapping counters of accepted and out-of-order
//                        packets.
// ---------------------------------------------------------------------------
module tcp_rx_seq_engine
  import packet_struct_pkg::*;
  import tcp_misc_pkg::*;
  import tcp_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       rx_pkt_hdr_val,
  input  logic [FLOWID_W-1:0]        rx_pkt_flowid,
  input  tcp_pkt_hdr                 rx_pkt_hdr,
  input  payload_buf_struct          rx_pkt_payload,
  output logic                       rx_pkt_hdr_rdy,

  output logic                       rx_pipe_rx_state_rd_req_val,
  output logic [FLOWID_W-1:0]        rx_pipe_rx_state_rd_req_addr,
  input  logic                       rx_state_rx_pipe_rd_req_rdy,

  input  logic                       rx_state_rx_pipe_rd_resp_val,
  input  smol_rx_state_struct        rx_state_rx_pipe_rd_resp_data,
  output logic                       rx_pipe_rx_state_rd_resp_rdy,

  output logic                       rx_pipe_rx_state_wr_req_val,
  output logic [FLOWID_W-1:0]        rx_pipe_rx_state_wr_req_addr,
  output smol_rx_state_struct        rx_pipe_rx_state_wr_req_data,
  input  logic                       rx_state_rx_pipe_wr_req_rdy,

  output logic                       rx_sched_update_val,
  output sched_cmd_struct            rx_sched_update_cmd,
  input  logic                       sched_rx_update_rdy,

  output logic                       rx_buf_commit_val,
  output logic [FLOWID_W-1:0]        rx_buf_commit_flowid,
  output payload_buf_struct          rx_buf_commit_payload,
  input  logic                       rx_buf_commit_rdy
`ifdef TCP_RX_SEQ_STATS_EN
  ,
  output logic [31:0]                rx_stat_accept_cnt,
  output logic [31:0]                rx_stat_ooo_cnt
`endif
);

  rx_seq_state_e state;

  logic [FLOWID_W-1:0]  flowid_r;
  logic [TCP_SEQ_W-1:0] seq_r;
  logic                 fin_r;
  payload_buf_struct    payload_r;
  smol_rx_state_struct  rx_state_r;

  logic                 need_wr_r;
  logic                 need_commit_r;
  logic                 need_sched_r;
  logic [TCP_SEQ_W-1:0] new_ack_r;

  logic                 wr_done;
  logic                 commit_done;
  logic                 sched_done;

  logic                 calc_in_order;
  logic                 calc_accept;
  logic                 calc_has_adv;
  logic                 calc_commit;
  logic [TCP_SEQ_W-1:0] calc_new_ack;

  logic                 wr_fire;
  logic                 commit_fire;
  logic                 sched_fire;
  logic                 all_done;

  // Header fields beyond seq/FIN are parsed upstream but not needed here
  logic                 unused_ok;
  assign unused_ok = &{1'b0, rx_pkt_hdr, calc_in_order};

  tcp_rx_seq_calc u_calc (
    .exp_ack     (rx_state_r.our_ack_state.ack_num),
    .seq_num     (seq_r),
    .payload_len (payload_r.payload_len),
    .fin         (fin_r),
    .in_order    (calc_in_order),
    .accept      (calc_accept),
    .has_adv     (calc_has_adv),
    .commit      (calc_commit),
    .new_ack     (calc_new_ack)
  );

  // Every valid comes from registered state only, so nothing here loops
  // back combinationally through a partner's ready.
  assign rx_pkt_hdr_rdy               = (state == IDLE);
  assign rx_pipe_rx_state_rd_req_val  = (state == RD_REQ);
  assign rx_pipe_rx_state_rd_req_addr = flowid_r;
  assign rx_pipe_rx_state_rd_resp_rdy = (state == RD_RESP);

  assign rx_pipe_rx_state_wr_req_val  = (state == OUT) && need_wr_r     && !wr_done;
  assign rx_buf_commit_val            = (state == OUT) && need_commit_r && !commit_done;
  assign rx_sched_update_val          = (state == OUT) && need_sched_r  && !sched_done;

  assign rx_pipe_rx_state_wr_req_addr = flowid_r;
  assign rx_buf_commit_flowid         = flowid_r;
  assign rx_buf_commit_payload        = payload_r;
  assign rx_sched_update_cmd          = build_ack_pending_cmd(flowid_r);

  // Write-back is the state read earlier with only ack_num replaced
  always_comb begin
    rx_pipe_rx_state_wr_req_data                       = rx_state_r;
    rx_pipe_rx_state_wr_req_data.our_ack_state.ack_num = new_ack_r;
  end

  assign wr_fire     = rx_pipe_rx_state_wr_req_val && rx_state_rx_pipe_wr_req_rdy;
  assign commit_fire = rx_buf_commit_val && rx_buf_commit_rdy;
  assign sched_fire  = rx_sched_update_val && sched_rx_update_rdy;

  // An output counts as finished if it was never needed, already went out,
  // or is handshaking right now; that lets a pure ACK leave OUT at once.
  assign all_done = (!need_wr_r     || wr_done     || wr_fire)     &&
                    (!need_commit_r || commit_done || commit_fire) &&
                    (!need_sched_r  || sched_done  || sched_fire);

  // Packet FSM: capture, read state, compute, then drain the three outputs
  // with one sticky done bit each. Reset drops any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      flowid_r      <= '0;
      seq_r         <= '0;
      fin_r         <= 1'b0;
      payload_r     <= '0;
      rx_state_r    <= '0;
      need_wr_r     <= 1'b0;
      need_commit_r <= 1'b0;
      need_sched_r  <= 1'b0;
      new_ack_r     <= '0;
      wr_done       <= 1'b0;
      commit_done   <= 1'b0;
      sched_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_pkt_hdr_val) begin
            flowid_r  <= rx_pkt_flowid;
            seq_r     <= rx_pkt_hdr.seq_num;
            fin_r     <= rx_pkt_hdr.flags[TCP_FLAG_FIN];
            payload_r <= rx_pkt_payload;
            state     <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (rx_state_rx_pipe_rd_req_rdy) begin
            state <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (rx_state_rx_pipe_rd_resp_val) begin
            rx_state_r <= rx_state_rx_pipe_rd_resp_data;
            state      <= CALC;
          end
        end
        CALC: begin
          need_wr_r     <= calc_accept;
          need_commit_r <= calc_commit;
          need_sched_r  <= calc_has_adv;
          new_ack_r     <= calc_new_ack;
          wr_done       <= 1'b0;
          commit_done   <= 1'b0;
          sched_done    <= 1'b0;
          state         <= OUT;
        end
        OUT: begin
          if (all_done) begin
            wr_done     <= 1'b0;
            commit_done <= 1'b0;
            sched_done  <= 1'b0;
            state       <= IDLE;
          end else begin
            if (wr_fire)     wr_done     <= 1'b1;
            if (commit_fire) commit_done <= 1'b1;
            if (sched_fire)  sched_done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TCP_RX_SEQ_STATS_EN
  // Statistics are sampled on the single CALC cycle of each packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_stat_accept_cnt <= '0;
      rx_stat_ooo_cnt    <= '0;
    end else if (state == CALC) begin
      if (calc_accept)    rx_stat_accept_cnt <= rx_stat_accept_cnt + 32'd1;
      if (!calc_in_order) rx_stat_ooo_cnt    <= rx_stat_ooo_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tcp_rx_seq_engine.sv
// ---------------------------------------------------------------------------
// Testbench for tcp_rx_seq_engine. Models a 1-cycle synchronous state RAM
// and always-ready (or selectively stalled) output partners, counts every
// handshake, and checks directed packets against hand-computed results.
// ---------------------------------------------------------------------------
module tb_tcp_rx_seq_engine;

  import packet_struct_pkg::*;
  import tcp_misc_pkg::*;
  import tcp_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic                rx_pkt_hdr_val;
  logic [FLOWID_W-1:0] rx_pkt_flowid;
  tcp_pkt_hdr          rx_pkt_hdr;
  payload_buf_struct   rx_pkt_payload;
  logic                rx_pkt_hdr_rdy;
  logic                rd_req_val;
  logic [FLOWID_W-1:0] rd_req_addr;
  logic                rd_req_rdy;
  logic                rd_resp_val;
  smol_rx_state_struct rd_resp_data;
  logic                rd_resp_rdy;
  logic                wr_val;
  logic [FLOWID_W-1:0] wr_addr;
  smol_rx_state_struct wr_data;
  logic                wr_rdy;
  logic                sched_val;
  sched_cmd_struct     sched_cmd;
  logic                sched_rdy;
  logic                commit_val;
  logic [FLOWID_W-1:0] commit_flowid;
  payload_buf_struct   commit_payload;
  logic                commit_rdy;
`ifdef TCP_RX_SEQ_STATS_EN
  logic [31:0]         stat_accept_cnt;
  logic [31:0]         stat_ooo_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  tcp_rx_seq_engine dut (
    .clk                           (clk),
    .rst                           (rst),
    .rx_pkt_hdr_val                (rx_pkt_hdr_val),
    .rx_pkt_flowid                 (rx_pkt_flowid),
    .rx_pkt_hdr                    (rx_pkt_hdr),
    .rx_pkt_payload                (rx_pkt_payload),
    .rx_pkt_hdr_rdy                (rx_pkt_hdr_rdy),
    .rx_pipe_rx_state_rd_req_val   (rd_req_val),
    .rx_pipe_rx_state_rd_req_addr  (rd_req_addr),
    .rx_state_rx_pipe_rd_req_rdy   (rd_req_rdy),
    .rx_state_rx_pipe_rd_resp_val  (rd_resp_val),
    .rx_state_rx_pipe_rd_resp_data (rd_resp_data),
    .rx_pipe_rx_state_rd_resp_rdy  (rd_resp_rdy),
    .rx_pipe_rx_state_wr_req_val   (wr_val),
    .rx_pipe_rx_state_wr_req_addr  (wr_addr),
    .rx_pipe_rx_state_wr_req_data  (wr_data),
    .rx_state_rx_pipe_wr_req_rdy   (wr_rdy),
    .rx_sched_update_val           (sched_val),
    .rx_sched_update_cmd           (sched_cmd),
    .sched_rx_update_rdy           (sched_rdy),
    .rx_buf_commit_val             (commit_val),
    .rx_buf_commit_flowid          (commit_flowid),
    .rx_buf_commit_payload         (commit_payload),
    .rx_buf_commit_rdy             (commit_rdy)
`ifdef TCP_RX_SEQ_STATS_EN
    ,
    .rx_stat_accept_cnt            (stat_accept_cnt),
    .rx_stat_ooo_cnt               (stat_ooo_cnt)
`endif
  );

  // State RAM model plus handshake monitors for the three outputs
  smol_rx_state_struct mem [0:(1<<FLOWID_W)-1];
  logic                resp_pending;
  smol_rx_state_struct resp_data_q;
  logic                preload_val;
  logic [FLOWID_W-1:0] preload_addr;
  smol_rx_state_struct preload_data;
  int                  wr_count     = 0;
  int                  commit_count = 0;
  int                  sched_count  = 0;
  smol_rx_state_struct last_wr_data;
  logic [FLOWID_W-1:0] last_wr_addr;
  payload_buf_struct   last_commit_payload;
  logic [FLOWID_W-1:0] last_commit_flowid;
  sched_cmd_struct     last_sched_cmd;

  assign rd_resp_val  = resp_pending;
  assign rd_resp_data = resp_data_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_pending <= 1'b0;
    end else begin
      if (preload_val) mem[preload_addr] <= preload_data;
      if (rd_req_val && rd_req_rdy) begin
        resp_pending <= 1'b1;
        resp_data_q  <= mem[rd_req_addr];
      end else if (rd_resp_val && rd_resp_rdy) begin
        resp_pending <= 1'b0;
      end
      if (wr_val && wr_rdy) begin
        mem[wr_addr] <= wr_data;
        wr_count     <= wr_count + 1;
        last_wr_data <= wr_data;
        last_wr_addr <= wr_addr;
      end
      if (commit_val && commit_rdy) begin
        commit_count        <= commit_count + 1;
        last_commit_payload <= commit_payload;
        last_commit_flowid  <= commit_flowid;
      end
      if (sched_val && sched_rdy) begin
        sched_count    <= sched_count + 1;
        last_sched_cmd <= sched_cmd;
      end
    end
  end

  task automatic preload(input logic [FLOWID_W-1:0] addr, input logic [31:0] ack);
    @(negedge clk);
    preload_val                        = 1'b1;
    preload_addr                       = addr;
    preload_data.our_ack_state.ack_num = ack;
    preload_data.our_win               = 16'hABCD;
    @(negedge clk);
    preload_val = 1'b0;
  endtask

  // Present one packet while IDLE and release it after the accepting edge
  task automatic applyStimulus(input logic [FLOWID_W-1:0] flow, input logic [31:0] seq,
                               input logic [15:0] len, input logic fin);
    @(negedge clk);
    rx_pkt_hdr                      = '0;
    rx_pkt_hdr.seq_num              = seq;
    rx_pkt_hdr.ack_num              = 32'hDEAD_BEEF;
    rx_pkt_hdr.flags[TCP_FLAG_FIN]  = fin;
    rx_pkt_flowid                   = flow;
    rx_pkt_payload.payload_addr     = 32'h0004_0000 + {24'd0, flow};
    rx_pkt_payload.payload_len      = len;
    rx_pkt_hdr_val                  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_pkt_hdr_val = 1'b0;
  endtask

  // Cycles from acceptance (cycle 0) until IDLE is seen again, capped at 50
  task automatic wait_idle(output int lat);
    lat = 1;
    while (!rx_pkt_hdr_rdy && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks += 6;
    if (rd_req_val !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_rd_req_val got %b want 0", rd_req_val); end
    if (wr_val !== 1'b0)         begin n_fail++; $display("[TB] FAIL reset_wr_val got %b want 0", wr_val); end
    if (sched_val !== 1'b0)      begin n_fail++; $display("[TB] FAIL reset_sched_val got %b want 0", sched_val); end
    if (commit_val !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_commit_val got %b want 0", commit_val); end
    if (rx_pkt_hdr_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_hdr_rdy got %b want 1", rx_pkt_hdr_rdy); end
    if (rd_resp_rdy !== 1'b0)    begin n_fail++; $display("[TB] FAIL reset_resp_rdy got %b want 0", rd_resp_rdy); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_in_order;
    int lat, w0, c0, s0;
    preload(8'd3, 32'd1000);
    w0 = wr_count; c0 = commit_count; s0 = sched_count;
    applyStimulus(8'd3, 32'd1000, 16'd64, 1'b0);
    wait_idle(lat);
    n_checks += 10;
    if (lat !== 5) begin n_fail++; $display("[TB] FAIL inorder_latency got %0d want 5", lat); end
    if (wr_count - w0 !== 1) begin n_fail++; $display("[TB] FAIL inorder_wr_count got %0d want 1", wr_count - w0); end
    if (last_wr_addr !== 8'd3) begin n_fail++; $display("[TB] FAIL inorder_wr_addr got %0d want 3", last_wr_addr); end
    if (last_wr_data.our_ack_state.ack_num !== 32'd1064) begin n_fail++; $display("[TB] FAIL inorder_ack got %0d want 1064", last_wr_data.our_ack_state.ack_num); end
    if (last_wr_data.our_win !== 16'hABCD) begin n_fail++; $display("[TB] FAIL inorder_win_passthru got %h want abcd", last_wr_data.our_win); end
    if (commit_count - c0 !== 1) begin n_fail++; $display("[TB] FAIL inorder_commit_count got %0d want 1", commit_count - c0); end
    if (last_commit_payload.payload_len !== 16'd64) begin n_fail++; $display("[TB] FAIL inorder_commit_len got %0d want 64", last_commit_payload.payload_len); end
    if (last_commit_flowid !== 8'd3) begin n_fail++; $display("[TB] FAIL inorder_commit_flow got %0d want 3", last_commit_flowid); end
    if (sched_count - s0 !== 1) begin n_fail++; $display("[TB] FAIL inorder_sched_count got %0d want 1", sched_count - s0); end
    if (last_sched_cmd.flowid !== 8'd3 || last_sched_cmd.set_ack_pending !== 1'b1) begin
      n_fail++; $display("[TB] FAIL inorder_sched_cmd got flow %0d ack %b want flow 3 ack 1", last_sched_cmd.flowid, last_sched_cmd.set_ack_pending);
    end
  endtask

  task automatic test_out_of_order;
    int lat, w0, c0, s0;
    preload(8'd4, 32'd1000);
    w0 = wr_count; c0 = commit_count; s0 = sched_count;
    applyStimulus(8'd4, 32'd2000, 16'd64, 1'b0);
    wait_idle(lat);
    n_checks += 5;
    if (lat !== 5) begin n_fail++; $display("[TB] FAIL ooo_latency got %0d want 5", lat); end
    if (wr_count - w0 !== 0) begin n_fail++; $display("[TB] FAIL ooo_wr_count got %0d want 0", wr_count - w0); end
    if (commit_count - c0 !== 0) begin n_fail++; $display("[TB] FAIL ooo_commit_count got %0d want 0", commit_count - c0); end
    if (sched_count - s0 !== 1) begin n_fail++; $display("[TB] FAIL ooo_sched_count got %0d want 1", sched_count - s0); end
    if (mem[4].our_ack_state.ack_num !== 32'd1000) begin n_fail++; $display("[TB] FAIL ooo_ack_unchanged got %0d want 1000", mem[4].our_ack_state.ack_num); end
  endtask

  task automatic test_wrap;
    int lat, c0;
    preload(8'd5, 32'hFFFF_FFF0);
    c0 = commit_count;
    applyStimulus(8'd5, 32'hFFFF_FFF0, 16'd32, 1'b0);
    wait_idle(lat);
    n_checks += 2;
    if (mem[5].our_ack_state.ack_num !== 32'h0000_0010) begin n_fail++; $display("[TB] FAIL wrap_ack got %h want 00000010", mem[5].our_ack_state.ack_num); end
    if (commit_count - c0 !== 1) begin n_fail++; $display("[TB] FAIL wrap_commit_count got %0d want 1", commit_count - c0); end
  endtask

  task automatic test_fin_and_pure_ack;
    int lat, w0, c0, s0;
    preload(8'd6, 32'd500);
    w0 = wr_count; c0 = commit_count; s0 = sched_count;
    applyStimulus(8'd6, 32'd500, 16'd0, 1'b1);
    wait_idle(lat);
    n_checks += 4;
    if (wr_count - w0 !== 1) begin n_fail++; $display("[TB] FAIL fin_wr_count got %0d want 1", wr_count - w0); end
    if (mem[6].our_ack_state.ack_num !== 32'd501) begin n_fail++; $display("[TB] FAIL fin_ack got %0d want 501", mem[6].our_ack_state.ack_num); end
    if (commit_count - c0 !== 0) begin n_fail++; $display("[TB] FAIL fin_commit_count got %0d want 0", commit_count - c0); end
    if (sched_count - s0 !== 1) begin n_fail++; $display("[TB] FAIL fin_sched_count got %0d want 1", sched_count - s0); end
    // Pure ACK at the now-expected sequence number: nothing goes out
    w0 = wr_count; c0 = commit_count; s0 = sched_count;
    applyStimulus(8'd6, 32'd501, 16'd0, 1'b0);
    wait_idle(lat);
    n_checks += 4;
    if (lat !== 5) begin n_fail++; $display("[TB] FAIL pureack_latency got %0d want 5", lat); end
    if (wr_count - w0 !== 0) begin n_fail++; $display("[TB] FAIL pureack_wr_count got %0d want 0", wr_count - w0); end
    if (commit_count - c0 !== 0) begin n_fail++; $display("[TB] FAIL pureack_commit_count got %0d want 0", commit_count - c0); end
    if (sched_count - s0 !== 0) begin n_fail++; $display("[TB] FAIL pureack_sched_count got %0d want 0", sched_count - s0); end
  endtask

  task automatic test_backpressure;
    int lat, n, w0, c0, s0;
    logic stable_ok, rdy_low_ok, others_low_ok;
    payload_buf_struct snap;
    preload(8'd7, 32'd100);
    w0 = wr_count; c0 = commit_count; s0 = sched_count;
    commit_rdy = 1'b0;
    applyStimulus(8'd7, 32'd100, 16'd10, 1'b0);
    n = 0;
    while (!commit_val && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks += 1;
    if (commit_val !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_commit_val_seen got %b want 1", commit_val); end
    snap = commit_payload;
    stable_ok = 1'b1; rdy_low_ok = 1'b1; others_low_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (commit_val !== 1'b1 || commit_payload !== snap || commit_flowid !== 8'd7) stable_ok = 1'b0;
      if (rx_pkt_hdr_rdy !== 1'b0) rdy_low_ok = 1'b0;
      if (wr_val !== 1'b0 || sched_val !== 1'b0) others_low_ok = 1'b0;
    end
    n_checks += 4;
    if (stable_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_commit_stable got %b want 1", stable_ok); end
    if (rdy_low_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_hdr_rdy_low got %b want 1", rdy_low_ok); end
    if (others_low_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_wr_sched_dropped got %b want 1", others_low_ok); end
    if (snap.payload_len !== 16'd10) begin n_fail++; $display("[TB] FAIL bp_commit_len got %0d want 10", snap.payload_len); end
    commit_rdy = 1'b1;
    wait_idle(lat);
    n_checks += 4;
    if (wr_count - w0 !== 1) begin n_fail++; $display("[TB] FAIL bp_wr_count got %0d want 1", wr_count - w0); end
    if (sched_count - s0 !== 1) begin n_fail++; $display("[TB] FAIL bp_sched_count got %0d want 1", sched_count - s0); end
    if (commit_count - c0 !== 1) begin n_fail++; $display("[TB] FAIL bp_commit_count got %0d want 1", commit_count - c0); end
    if (mem[7].our_ack_state.ack_num !== 32'd110) begin n_fail++; $display("[TB] FAIL bp_ack got %0d want 110", mem[7].our_ack_state.ack_num); end
  endtask

  task automatic test_reset_mid_out;
    int lat, n;
    preload(8'd8, 32'd200);
    wr_rdy = 1'b0;
    applyStimulus(8'd8, 32'd200, 16'd8, 1'b0);
    n = 0;
    while (!wr_val && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks += 1;
    if (wr_val !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_wr_pending got %b want 1", wr_val); end
    rst = 1'b1;
    #1;
    n_checks += 4;
    if (wr_val !== 1'b0 || sched_val !== 1'b0 || commit_val !== 1'b0 || rd_req_val !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rstmid_vals got wr %b sched %b commit %b rd %b want all 0", wr_val, sched_val, commit_val, rd_req_val);
    end
    if (rx_pkt_hdr_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_hdr_rdy got %b want 1", rx_pkt_hdr_rdy); end
    if (rd_resp_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_resp_rdy got %b want 0", rd_resp_rdy); end
    wr_rdy = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (mem[8].our_ack_state.ack_num !== 32'd200) begin n_fail++; $display("[TB] FAIL rstmid_no_write got %0d want 200", mem[8].our_ack_state.ack_num); end
    applyStimulus(8'd8, 32'd200, 16'd8, 1'b0);
    wait_idle(lat);
    n_checks += 2;
    if (lat !== 5) begin n_fail++; $display("[TB] FAIL rstmid_next_latency got %0d want 5", lat); end
    if (mem[8].our_ack_state.ack_num !== 32'd208) begin n_fail++; $display("[TB] FAIL rstmid_next_ack got %0d want 208", mem[8].our_ack_state.ack_num); end
  endtask

  initial begin
    rst            = 1'b1;
    rx_pkt_hdr_val = 1'b0;
    rx_pkt_flowid  = '0;
    rx_pkt_hdr     = '0;
    rx_pkt_payload = '0;
    rd_req_rdy     = 1'b1;
    wr_rdy         = 1'b1;
    sched_rdy      = 1'b1;
    commit_rdy     = 1'b1;
    preload_val    = 1'b0;
    preload_addr   = '0;
    preload_data   = '0;
    test_reset();
    test_in_order();
    test_out_of_order();
    test_wrap();
    test_fin_and_pure_ack();
    test_backpressure();
    test_reset_mid_out();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog_timeout got running want finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
